// File: rtl/vcmd_v3.sv
// vcmd_v3 - video command receiver and framebuffer write-address generator.
//
// Takes a C/D tagged byte stream from the host link and turns it into
// registered VRAM write strobes. Command bytes program the write address
// (SetAddr), the address increment (SetStride) or start a hardware block
// fill (Fill). Data bytes are written at the current address, which then
// advances by the stride.
//
// Ports:
//   ClkIn          system clock
//   RstIn          synchronous active-high reset
//   ByteIn         input byte
//   ByteValidIn    ByteIn valid this cycle
//   DataModeEnable C/D tag: 0 = command byte, 1 = data byte
//   ReadyOut       byte accepted when ByteValidIn & ReadyOut (low only while filling)
//   WriteEnOut     one-cycle write strobe
//   AddrOut        write address, qualified by WriteEnOut
//   DataOut        write data, qualified by WriteEnOut
//   ErrOut         one-cycle pulse on protocol error
module vcmd_v3 #(
  parameter int AWIDTH = 18,
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              ClkIn,
  input  logic              RstIn,
  input  logic [DWIDTH-1:0] ByteIn,
  input  logic              ByteValidIn,
  input  logic              DataModeEnable,
  output logic              ReadyOut,
  output logic              WriteEnOut,
  output logic [AWIDTH-1:0] AddrOut,
  output logic [DWIDTH-1:0] DataOut,
  output logic              ErrOut
);

  localparam int ADDR_BYTES = (AWIDTH + 7) / 8;
  localparam int CNT_BYTES  = CWIDTH / 8;
  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0] CNT_LAST  = 3'(CNT_BYTES - 1);

  localparam logic [DWIDTH-1:0] CMD_NOOP   = 8'h00;
  localparam logic [DWIDTH-1:0] CMD_ADDR   = 8'h01;
  localparam logic [DWIDTH-1:0] CMD_STRIDE = 8'h02;
  localparam logic [DWIDTH-1:0] CMD_FILL   = 8'h03;

  typedef enum logic [2:0] {
    ST_READ_CMD,
    ST_ADDR_BYTE,
    ST_STRIDE,
    ST_FILL_COUNT,
    ST_FILL_VALUE,
    ST_FILL_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] stride_q, stride_d;
  logic [AWIDTH-1:0] shadow_q, shadow_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [CWIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [DWIDTH-1:0] fill_val_q, fill_val_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_out_q, addr_out_d;
  logic [DWIDTH-1:0] data_out_q, data_out_d;
  logic              err_q, err_d;

  // ready_q is low exactly while state_q is ST_FILL_RUN, so no byte is
  // ever accepted during a fill run.
  logic accept;
  assign accept = ByteValidIn & ready_q;

  // State register plus datapath/output registers.
  always_ff @(posedge ClkIn) begin
    if (RstIn) begin
      state_q    <= ST_READ_CMD;
      addr_q     <= '0;
      stride_q   <= AWIDTH'(1);
      shadow_q   <= '0;
      byte_cnt_q <= '0;
      fill_cnt_q <= '0;
      fill_val_q <= '0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      addr_out_q <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      shadow_q   <= shadow_d;
      byte_cnt_q <= byte_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      fill_val_q <= fill_val_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (DataModeEnable) begin
        // A data byte always ends any partial command.
        state_d = ST_READ_CMD;
      end else begin
        case (state_q)
          ST_READ_CMD: begin
            case (ByteIn)
              CMD_ADDR:   state_d = ST_ADDR_BYTE;
              CMD_STRIDE: state_d = ST_STRIDE;
              CMD_FILL:   state_d = ST_FILL_COUNT;
              default:    state_d = ST_READ_CMD;
            endcase
          end
          ST_ADDR_BYTE:  if (byte_cnt_q == ADDR_LAST) state_d = ST_READ_CMD;
          ST_STRIDE:     state_d = ST_READ_CMD;
          ST_FILL_COUNT: if (byte_cnt_q == CNT_LAST) state_d = ST_FILL_VALUE;
          // The first fill write is issued together with the value byte,
          // so a count of 0 or 1 never needs the run state.
          ST_FILL_VALUE: state_d = (fill_cnt_q > CWIDTH'(1)) ? ST_FILL_RUN : ST_READ_CMD;
          default:       state_d = ST_READ_CMD;
        endcase
      end
    end else if (state_q == ST_FILL_RUN) begin
      if (fill_cnt_q == CWIDTH'(1)) state_d = ST_READ_CMD;
    end
  end

  // Datapath and output next-values.
  always_comb begin
    addr_d     = addr_q;
    stride_d   = stride_q;
    shadow_d   = shadow_q;
    byte_cnt_d = byte_cnt_q;
    fill_cnt_d = fill_cnt_q;
    fill_val_d = fill_val_q;
    we_d       = 1'b0;
    addr_out_d = addr_out_q;
    data_out_d = data_out_q;
    err_d      = 1'b0;

    if (accept) begin
      if (DataModeEnable) begin
        we_d       = 1'b1;
        addr_out_d = addr_q;
        data_out_d = ByteIn;
        addr_d     = addr_q + stride_q;
        err_d      = (state_q != ST_READ_CMD);
        byte_cnt_d = '0;
      end else begin
        case (state_q)
          ST_READ_CMD: begin
            byte_cnt_d = '0;
            err_d      = (ByteIn > CMD_FILL);
          end
          ST_ADDR_BYTE: begin
            // Shift MSB-first; bits above AWIDTH fall off the top.
            shadow_d   = AWIDTH'({shadow_q, ByteIn});
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (byte_cnt_q == ADDR_LAST) addr_d = AWIDTH'({shadow_q, ByteIn});
          end
          ST_STRIDE: begin
            stride_d = AWIDTH'(ByteIn);
          end
          ST_FILL_COUNT: begin
            fill_cnt_d = CWIDTH'({fill_cnt_q, ByteIn});
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
          ST_FILL_VALUE: begin
            fill_val_d = ByteIn;
            if (fill_cnt_q != '0) begin
              we_d       = 1'b1;
              addr_out_d = addr_q;
              data_out_d = ByteIn;
              addr_d     = addr_q + stride_q;
              fill_cnt_d = fill_cnt_q - CWIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end else if (state_q == ST_FILL_RUN) begin
      // fill_cnt_q holds the writes still owed, including this one.
      we_d       = 1'b1;
      addr_out_d = addr_q;
      data_out_d = fill_val_q;
      addr_d     = addr_q + stride_q;
      fill_cnt_d = fill_cnt_q - CWIDTH'(1);
    end
  end

  // Ready is registered: high again on the cycle the last fill write shows.
  assign ready_d = (state_d != ST_FILL_RUN);

  assign ReadyOut   = ready_q;
  assign WriteEnOut = we_q;
  assign AddrOut    = addr_out_q;
  assign DataOut    = data_out_q;
  assign ErrOut     = err_q;

endmodule
